and4_sweep_ctrl: RTL and testbench

Self-checking sequencer for the four-input AND gate datapath (inputs a, b, c, d; outputs e = a&b, f = c&d, g = e&f). On a start request it drives all 16 input combinations in order and holds each one for a programmable settle time. It then samples e/f/g and compares them against an internal expected model, accumulating an error count, a sticky per-output error mask and the first failing vector. It sits between the lab control logic and the gate instance and replaces free-running toggle stimulus with a deterministic, clocked sweep.

---
 rtl/and4_pkg.sv | 8 +
 rtl/and4_ref_model.sv | 13 +
 rtl/and4_sweep_ctrl.sv | 104 ++++++++++
 tb/tb_and4_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/and4_pkg.sv
// and4_pkg: shared types and constants for the AND4 sweep controller
package and4_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;
  localparam logic [3:0] VEC_LAST = 4'hF;
  localparam int ERR_E = 0;
  localparam int ERR_F = 1;
  localparam int ERR_G = 2;
endpackage

// File: rtl/and4_ref_model.sv
// and4_ref_model: golden {g,f,e} of the AND4 datapath for a stimulus vector
module and4_ref_model
  import and4_pkg::*;
(
  input  logic [3:0] vec_i,
  output logic [2:0] exp_o
);
  always_comb begin
    exp_o[ERR_E] = vec_i[3] & vec_i[2];
    exp_o[ERR_F] = vec_i[1] & vec_i[0];
    exp_o[ERR_G] = &vec_i;
  end
endmodule

// File: rtl/and4_sweep_ctrl.sv
// and4_sweep_ctrl: clocked 16-vector sweep of the AND4 gate with error capture
module and4_sweep_ctrl
  import and4_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       err_mask,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] vec_q, vec_d, fev_q, fev_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [2:0] mask_q, mask_d, exp_gfe, diff;
  logic fv_q, fv_d, busy_q, done_q;
  and4_ref_model u_ref (.vec_i(vec_q), .exp_o(exp_gfe));
  assign diff = {g, f, e} ^ exp_gfe;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    fev_d = fev_q;
    fv_d = fv_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        hold_d = HOLD_LOAD;
        vec_d = '0;
        cnt_d = '0;
        mask_d = '0;
        fev_d = '0;
        fv_d = 1'b0;
      end
      APPLY: begin
        state_d = hold_q == '0 ? CHECK : APPLY;
        hold_d = hold_q == '0 ? hold_q : hold_q - 1'b1;
      end
      CHECK: begin
        state_d = vec_q == VEC_LAST ? DONE : APPLY;
        hold_d = HOLD_LOAD;
        vec_d = vec_q + 1'b1;  // wraps to 0 on the way into DONE
        if (|diff) begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
          mask_d = mask_q | diff;
          fev_d = fv_q ? fev_q : vec_q;
          fv_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      vec_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      fev_q <= '0;
      fv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      fev_q <= fev_d;
      fv_q <= fv_d;
      busy_q <= state_d inside {APPLY, CHECK};
      done_q <= state_d == DONE;
    end
  end
  assign {a, b, c, d} = vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err_cnt = cnt_q;
  assign err_mask = mask_q;
  assign first_err_vec = fev_q;
  assign first_err_valid = fv_q;
endmodule

// File: tb/tb_and4_sweep_ctrl.sv
// tb_and4_sweep_ctrl: two sweep controllers (HOLD 2/ERR_W 5 and HOLD 1/ERR_W 2)
// driving faulty gate models, checked cycle by cycle against a timing model.
module tb_and4_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start_r [2];
  int mode [2];
  logic busy0, done0, a0, b0, c0, d0, e0, f0, g0, fv0;
  logic busy1, done1, a1, b1, c1, d1, e1, f1, g1, fv1;
  logic [4:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] mask0, mask1;
  logic [3:0] fev0, fev1;
  int checks = 0;
  int failures = 0;
  localparam int HP [2] = '{3, 2};
  localparam int CMAX [2] = '{31, 3};
  logic act [2];
  int t [2];
  int mcnt [2];
  logic [2:0] mmask [2];
  logic [3:0] mfev [2];
  logic mfv [2];
  logic armed = 1'b0;
  logic [18:0] got_v, want_v;
  int n, nd, n1, n2;
  bit seen;

  always #5 clk = ~clk;

  function automatic logic [2:0] ideal_out(int v);
    return {v == 15, v % 4 == 3, v / 4 == 3};
  endfunction

  // mode 0 ideal, 1 g stuck 0, 2 f wired as c|d (g follows bad f), 3 e stuck 1
  function automatic logic [2:0] gate_out(int md, int v);
    logic ee, ff, gg;
    ee = md == 3 ? 1'b1 : v / 4 == 3;
    ff = md == 2 ? v % 4 != 0 : v % 4 == 3;
    gg = md == 1 ? 1'b0 : md == 2 ? (v / 4 == 3) && ff : v == 15;
    return {gg, ff, ee};
  endfunction

  assign {g0, f0, e0} = gate_out(mode[0], int'({a0, b0, c0, d0}));
  assign {g1, f1, e1} = gate_out(mode[1], int'({a1, b1, c1, d1}));

  and4_sweep_ctrl #(.HOLD_CYCLES(2), .ERR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start_r[0]), .busy(busy0), .done(done0),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .err_cnt(cnt0), .err_mask(mask0), .first_err_vec(fev0), .first_err_valid(fv0)
  );

  and4_sweep_ctrl #(.HOLD_CYCLES(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .busy(busy1), .done(done1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .err_cnt(cnt1), .err_mask(mask1), .first_err_vec(fev1), .first_err_valid(fv1)
  );

  // t counts cycles since the accepting edge; vector n is judged at t = (n+1)*HP
  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        t[i] <= 0;
        mcnt[i] <= 0;
        mmask[i] <= '0;
        mfev[i] <= '0;
        mfv[i] <= 1'b0;
      end else if (!act[i]) begin
        if (start_r[i]) begin
          act[i] <= 1'b1;
          t[i] <= 1;
          mcnt[i] <= 0;
          mmask[i] <= '0;
          mfev[i] <= '0;
          mfv[i] <= 1'b0;
        end
      end else begin
        t[i] <= t[i] + 1;
        if (t[i] == 16 * HP[i] + 1) act[i] <= 1'b0;
        if (t[i] % HP[i] == 0 && t[i] <= 16 * HP[i] &&
            gate_out(mode[i], t[i] / HP[i] - 1) != ideal_out(t[i] / HP[i] - 1)) begin
          mcnt[i] <= mcnt[i] == CMAX[i] ? mcnt[i] : mcnt[i] + 1;
          mmask[i] <= mmask[i] | (gate_out(mode[i], t[i] / HP[i] - 1) ^ ideal_out(t[i] / HP[i] - 1));
          mfev[i] <= mfv[i] ? mfev[i] : 4'(t[i] / HP[i] - 1);
          mfv[i] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [18:0] model_out(int i);
    logic bz, dn;
    logic [3:0] v;
    bz = act[i] && t[i] <= 16 * HP[i];
    dn = act[i] && t[i] == 16 * HP[i] + 1;
    v = bz ? 4'((t[i] - 1) / HP[i]) : 4'd0;
    return {bz, dn, v, 5'(mcnt[i]), mmask[i], mfev[i], mfv[i]};
  endfunction

  function automatic logic [18:0] dut_out(int i);
    return i == 0 ? {busy0, done0, a0, b0, c0, d0, cnt0, mask0, fev0, fv0}
                  : {busy1, done1, a1, b1, c1, d1, 3'b000, cnt1, mask1, fev1, fv1};
  endfunction

  function automatic logic done_of(int i);
    return i == 0 ? done0 : done1;
  endfunction

  function automatic logic [3:0] vec_of(int i);
    return i == 0 ? {a0, b0, c0, d0} : {a1, b1, c1, d1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic sweep(input int i, input int md, input bit mid, input int edone, input int ecnt,
                       input logic [2:0] emask, input logic [3:0] efev, input logic efv);
    int k;
    bit dn, pulsed;
    mode[i] = md;
    k = 0;
    dn = 0;
    pulsed = 0;
    @(negedge clk);
    start_r[i] = 1'b1;
    @(posedge clk);
    #1 start_r[i] = 1'b0;
    while (!dn && k < 200) begin
      @(negedge clk);
      k++;
      if (done_of(i)) dn = 1;
      else if (mid && !pulsed && vec_of(i) == 4'd6) begin
        start_r[i] = 1'b1;
        pulsed = 1;
      end else start_r[i] = 1'b0;
    end
    chk("done_cycle", k, edone);
    chk("err_cnt", i == 0 ? 32'(cnt0) : 32'(cnt1), ecnt);
    chk("err_mask", i == 0 ? mask0 : mask1, emask);
    chk("first_err_vec", i == 0 ? fev0 : fev1, efev);
    chk("first_err_valid", i == 0 ? fv0 : fv1, efv);
  endtask

  initial begin
    rst = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    mode[0] = 0;
    mode[1] = 3;
    fork
      forever begin
        @(negedge clk);
        if (armed)
          for (int i = 0; i < 2; i++) begin
            got_v = dut_out(i);
            want_v = model_out(i);
            checks++;
            if (got_v !== want_v) begin
              failures++;
              $display("FAIL cycle_compare dut%0d time=%0t got=%h want=%h", i, $time, got_v, want_v);
            end
          end
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_vec", {a0, b0, c0, d0}, 0);
    chk("rst_err_cnt", cnt0, 0);
    chk("rst_first_valid", fv0, 0);
    chk("rst_busy1", busy1, 0);
    sweep(0, 0, 0, 49, 0, 3'b000, 4'h0, 1'b0);
    sweep(0, 1, 0, 49, 1, 3'b100, 4'hF, 1'b1);
    sweep(0, 2, 0, 49, 8, 3'b110, 4'h1, 1'b1);
    sweep(0, 1, 1, 49, 1, 3'b100, 4'hF, 1'b1);
    mode[0] = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    n = 0;
    while ({a0, b0, c0, d0} != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_before", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_vec", {a0, b0, c0, d0}, 0);
    chk("abort_done", done0, 0);
    chk("abort_err_cnt", cnt0, 0);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    sweep(0, 0, 0, 49, 0, 3'b000, 4'h0, 1'b0);
    @(negedge clk);
    start_r[0] = 1'b1;
    n = 0;
    nd = 0;
    n1 = 0;
    n2 = 0;
    while (n < 300 && nd < 2) begin
      @(negedge clk);
      n++;
      if (done0) begin
        if (nd == 0) n1 = n;
        else n2 = n;
        nd++;
      end
    end
    start_r[0] = 1'b0;
    chk("held_done_count", nd, 2);
    chk("held_done_gap", n2 - n1, 50);
    repeat (2) @(negedge clk);
    sweep(1, 3, 0, 33, 3, 3'b001, 4'h0, 1'b1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
